synapse_port_arbiter: RTL and testbench
=======================================

Name: synapse_port_arbiter

Overview:
- Owns the single port of the per-core synapse weight memory (128 x 32-bit).
- Shares that port between three requesters, each with a valid/ready interface:
  - AXI parameter writes (cfg)
  - STDP synaptic weight updates (swu)
  - Spike-driven synapse reads (spk), where a spike address carries one or two neuron IDs.
- Sits between the PN address decode and the synapse memory, and replaces the ad-hoc SWU_EN muxing.
- Sequences each granted transfer into registered memory strobes and returns read data tagged per neuron.

Parameters:
ADDR_W, 7, synapse memory address width
DATA_W, 32, synapse memory word width
SWU_W, 8, STDP update weight width (zero-extended to DATA_W)
STARVE_LIMIT, 8, lost IDLE arbitrations before cfg is promoted to top priority
CNT_W, 4, width of the cfg starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-low reset
cfg_valid  in  1  AXI write request
cfg_ready  out  1  AXI write accepted this cycle
cfg_addr  in  ADDR_W  write address
cfg_data  in  DATA_W  write data
swu_valid  in  1  STDP update request
swu_ready  out  1  STDP update accepted this cycle
swu_addr  in  ADDR_W  update address
swu_data  in  SWU_W  new weight
spk_valid  in  1  spike read request
spk_ready  out  1  spike accepted this cycle
spk_addr  in  2*ADDR_W  [6:0] first neuron ID, [13:7] second neuron ID; [13:7]==0 means single neuron
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid one cycle after mem_re
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  returned weight
rd_tag  out  1  0 = first neuron, 1 = second neuron
rd_last  out  1  final read of the current spike request
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - cfg_wait counter is cleared to 0.
  - All registered outputs go to 0: mem_we, mem_re, mem_addr, mem_wdata, rd_valid, rd_tag, rd_last, busy.
  - The ready outputs are 0 while rst==0.
  - A read in flight when reset hits is dropped: rd_valid is 0 on the cycle after reset.
- FSM states and transitions:
  - IDLE: the only state that can accept a request.
  - WR: one cycle with mem_we=1, then IDLE.
  - RD0: mem_re=1, mem_addr=first ID; goes to RD1 if the request is a pair, else to IDLE.
  - RD1: mem_re=1, mem_addr=second ID; then IDLE.
- Readies:
  - Combinational, high only in IDLE with rst==1, and for at most one requester per cycle.
  - A transfer occurs on the cycle where valid&&ready.
- Arbitration in IDLE:
  - Default priority is swu > spk > cfg.
  - If cfg_wait==STARVE_LIMIT, priority becomes cfg > swu > spk.
- cfg_wait counter:
  - Increments on each IDLE cycle where cfg_valid=1 and cfg is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on cfg grant or when cfg_valid=0.
- Write requests (accepted at cycle t):
  - At t+1 the block is in WR with mem_we=1.
  - cfg: mem_addr=cfg_addr, mem_wdata=cfg_data.
  - swu: mem_addr=swu_addr, mem_wdata={24'b0, swu_data}.
  - IDLE again at t+2.
- Spike requests (accepted at cycle t):
  - spk_addr is captured at acceptance.
  - mem_re=1 with the first ID at t+1.
  - For a pair, mem_re=1 with the second ID at t+2.
  - Outside reads, mem_addr and mem_wdata hold 0 whenever no strobe is asserted.
- Read return:
  - rd_valid is a one-cycle registered copy of mem_re.
  - rd_data = mem_rdata (combinational pass-through) while rd_valid=1.
  - rd_tag and rd_last are registered alongside rd_valid.
  - Single request: tag 0, last 1.
  - Pair: first beat tag 0, last 0; second beat tag 1, last 1.
- Throughput:
  - A write occupies 2 cycles (accept + WR).
  - A single spike read occupies 2 cycles (accept + RD0); a pair occupies 3.
  - The next accept happens in the IDLE cycle that follows.
- Boundary cases:
  - Second ID 0 with first ID 0 is a single read of address 0.
  - Valids deasserted without a handshake carry no obligation.
  - Requests arriving in a non-IDLE state wait; they are never dropped or queued internally.

Test Plan:
- Reset mid-operation:
  - Stimulus: accept a pair with spk_addr={7'd3,7'd9}; drive rst=0 during RD1 for 2 cycles.
  - Response: mem_re, rd_valid and busy are 0 the cycle after reset; spk_ready=1 once rst=1 and spk_valid=1.
- cfg write:
  - Stimulus: cfg_addr=7'h05, cfg_data=32'hDEADBEEF accepted at t.
  - Response: mem_we=1, mem_addr=5, mem_wdata=DEADBEEF, busy=1 at t+1; cfg_ready may reassert at t+2.
- Spike pair:
  - Stimulus: spk_addr={7'd3,7'd9} accepted at t.
  - Response: mem_re at t+1 with addr 9 and at t+2 with addr 3; rd_valid at t+2 (tag 0, last 0) and t+3 (tag 1, last 1); rd_data equals the model memory contents.
- Single spike:
  - Stimulus: spk_addr=14'h0011.
  - Response: exactly one mem_re with addr 0x11; one rd_valid beat with tag 0, last 1; IDLE at t+2.
- Simultaneous requests:
  - Stimulus: in the same cycle, swu (addr 2, data 8'hA5), spk 14'h0004 and cfg (addr 1) are all valid.
  - Response: the order of service is swu (mem_wdata=32'h000000A5), then spk, then cfg; only one ready is high per cycle.
- Starvation:
  - Stimulus: swu_valid held high continuously and cfg_valid=1.
  - Response: cfg is refused for 8 IDLE cycles and granted on the 9th IDLE cycle (cycle 17 from start); cfg_wait returns to 0 after the grant.

Source files
------------

// File: rtl/synapse_port_arbiter.sv
// rtl/synapse_port_arbiter.sv - single-port synapse memory arbiter for cfg, swu and spk requesters
// Grants one request per IDLE cycle and turns it into registered memory strobes and tagged read beats.
module synapse_port_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int SWU_W        = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                swu_valid,
  output logic                swu_ready,
  input  logic [ADDR_W-1:0]   swu_addr,
  input  logic [SWU_W-1:0]    swu_data,
  input  logic                spk_valid,
  output logic                spk_ready,
  input  logic [2*ADDR_W-1:0] spk_addr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_tag,
  output logic                rd_last,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WR, RD0, RD1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cfg_wait_q, cfg_wait_d;
  logic                pair_q, pair_d;
  logic [ADDR_W-1:0]   hi_q, hi_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_tag_q, rd_tag_d;
  logic                rd_last_q, rd_last_d;
  logic                busy_q, busy_d;

  logic promote, idle_ok, cfg_gnt, swu_gnt, spk_gnt;

  // Once cfg has lost STARVE_LIMIT IDLE arbitrations it jumps ahead of swu and spk.
  always_comb begin
    promote = (cfg_wait_q == CNT_W'(STARVE_LIMIT));
    idle_ok = (state_q == IDLE) && rst;
    cfg_gnt = idle_ok && cfg_valid && (promote || (!swu_valid && !spk_valid));
    swu_gnt = idle_ok && swu_valid && !(promote && cfg_valid);
    spk_gnt = idle_ok && spk_valid && !swu_valid && !(promote && cfg_valid);
  end

  assign cfg_ready = cfg_gnt;
  assign swu_ready = swu_gnt;
  assign spk_ready = spk_gnt;

  always_comb begin
    state_d     = state_q;
    cfg_wait_d  = cfg_wait_q;
    pair_d      = pair_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rd_valid_d  = mem_re_q;
    rd_tag_d    = (state_q == RD1);
    rd_last_d   = (state_q == RD1) || ((state_q == RD0) && !pair_q);

    if (!cfg_valid || cfg_gnt) begin
      cfg_wait_d = '0;
    end else if ((state_q == IDLE) && !promote) begin
      cfg_wait_d = cfg_wait_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (swu_gnt) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = swu_addr;
          mem_wdata_d = DATA_W'(swu_data);
        end else if (cfg_gnt) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = cfg_addr;
          mem_wdata_d = cfg_data;
        end else if (spk_gnt) begin
          state_d    = RD0;
          mem_re_d   = 1'b1;
          mem_addr_d = spk_addr[ADDR_W-1:0];
          hi_d       = spk_addr[2*ADDR_W-1:ADDR_W];
          pair_d     = (spk_addr[2*ADDR_W-1:ADDR_W] != '0);
        end
      end
      WR: state_d = IDLE;
      RD0: begin
        if (pair_q) begin
          state_d    = RD1;
          mem_re_d   = 1'b1;
          mem_addr_d = hi_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cfg_wait_q  <= '0;
      pair_q      <= 1'b0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_wait_q  <= cfg_wait_d;
      pair_q      <= pair_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? mem_rdata : '0;
  assign rd_tag    = rd_tag_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_synapse_port_arbiter.sv
// tb/tb_synapse_port_arbiter.sv - bench for synapse_port_arbiter
module tb_synapse_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, swu_valid, swu_ready, spk_valid, spk_ready;
  logic [6:0]  cfg_addr, swu_addr;
  logic [31:0] cfg_data;
  logic [7:0]  swu_data;
  logic [13:0] spk_addr;
  logic        mem_we, mem_re, rd_valid, rd_tag, rd_last, busy;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rd_data;

  always #5 clk = ~clk;

  synapse_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .swu_valid(swu_valid), .swu_ready(swu_ready), .swu_addr(swu_addr), .swu_data(swu_data),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .rd_last(rd_last), .busy(busy)
  );

  function automatic logic [31:0] fill(input int i);
    return 32'h1000_0000 ^ (i * 32'h9E37_79B1);
  endfunction

  logic [31:0] tbmem [0:127];
  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tbmem[mem_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic rst; logic cv; logic [6:0] ca; logic [31:0] cd;
    logic sv; logic [6:0] sa; logic [7:0] sd; logic pv; logic [13:0] pa;
    logic [2:0] rdy;
    logic we; logic re; logic [6:0] addr; logic [31:0] wd;
    logic rdv; logic [31:0] rdat; logic tag; logic last; logic busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic cv, input logic [6:0] ca, input logic [31:0] cd,
                              input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                              input logic pv, input logic [13:0] pa, input logic [2:0] rdy,
                              input logic we, input logic re, input logic [6:0] addr, input logic [31:0] wd,
                              input logic rdv, input logic [31:0] rdat, input logic tag, input logic last,
                              input logic bsy);
    vec_t v;
    v = '{r, cv, ca, cd, sv, sa, sd, pv, pa, rdy, we, re, addr, wd, rdv, rdat, tag, last, bsy};
    return v;
  endfunction

  typedef struct packed {
    logic we; logic re; logic [6:0] addr; logic [31:0] wdata;
    logic rdv; logic [31:0] rdata; logic tag; logic last; logic busy;
  } exp_t;

  vec_t        tbl [21];
  exp_t        slot [8];
  logic [31:0] model_mem [0:127];

  task automatic drive(input logic r, input logic cv, input logic [6:0] ca, input logic [31:0] cd,
                       input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                       input logic pv, input logic [13:0] pa);
    rst = r; cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
    swu_valid = sv; swu_addr = sa; swu_data = sd; spk_valid = pv; spk_addr = pa;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) tbmem[i] <= fill(i);

    tbl[0]  = mk(0,0,0,0,            0,0,0,     0,0,       3'b000, 0,0,0,0,             0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,            0,0,0,     1,14'h189, 3'b000, 0,0,0,0,             0,0,0,0,0);
    tbl[2]  = mk(1,1,7'h05,32'hDEADBEEF, 0,0,0, 0,0,       3'b100, 0,0,0,0,             0,0,0,0,0);
    tbl[3]  = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 1,0,7'h05,32'hDEADBEEF, 0,0,0,0,1);
    tbl[4]  = mk(1,0,0,0,            0,0,0,     1,14'h189, 3'b001, 0,0,0,0,             0,0,0,0,0);
    tbl[5]  = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,1,7'd9,0,          0,0,0,0,1);
    tbl[6]  = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,1,7'd3,0,          1,fill(9),0,0,1);
    tbl[7]  = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,0,0,0,             1,fill(3),1,1,0);
    tbl[8]  = mk(1,0,0,0,            0,0,0,     1,14'h011, 3'b001, 0,0,0,0,             0,0,0,0,0);
    tbl[9]  = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,1,7'h11,0,         0,0,0,0,1);
    tbl[10] = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,0,0,0,             1,fill(17),0,1,0);
    tbl[11] = mk(1,1,7'd1,32'h12345678, 1,7'd2,8'hA5, 1,14'h004, 3'b010, 0,0,0,0,        0,0,0,0,0);
    tbl[12] = mk(1,1,7'd1,32'h12345678, 0,0,0, 1,14'h004,  3'b000, 1,0,7'd2,32'h000000A5, 0,0,0,0,1);
    tbl[13] = mk(1,1,7'd1,32'h12345678, 0,0,0, 1,14'h004,  3'b001, 0,0,0,0,             0,0,0,0,0);
    tbl[14] = mk(1,1,7'd1,32'h12345678, 0,0,0, 0,0,        3'b000, 0,1,7'd4,0,          0,0,0,0,1);
    tbl[15] = mk(1,1,7'd1,32'h12345678, 0,0,0, 0,0,        3'b100, 0,0,0,0,             1,fill(4),0,1,0);
    tbl[16] = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 1,0,7'd1,32'h12345678, 0,0,0,0,1);
    tbl[17] = mk(1,0,0,0,            0,0,0,     1,14'h000, 3'b001, 0,0,0,0,             0,0,0,0,0);
    tbl[18] = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,1,7'd0,0,          0,0,0,0,1);
    tbl[19] = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,0,0,0,             1,fill(0),0,1,0);
    tbl[20] = mk(1,0,0,0,            0,0,0,     0,0,       3'b000, 0,0,0,0,             0,0,0,0,0);

    drive(0,0,0,0,0,0,0,0,0);
    step();
    step();

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].pv, tbl[i].pa);
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i), {29'd0, cfg_ready, swu_ready, spk_ready}, {29'd0, tbl[i].rdy});
      chk($sformatf("vec%0d.we", i), {31'd0, mem_we}, {31'd0, tbl[i].we});
      chk($sformatf("vec%0d.re", i), {31'd0, mem_re}, {31'd0, tbl[i].re});
      chk($sformatf("vec%0d.addr", i), {25'd0, mem_addr}, {25'd0, tbl[i].addr});
      chk($sformatf("vec%0d.wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("vec%0d.rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].rdv});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      if (tbl[i].rdv) begin
        chk($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].rdat);
        chk($sformatf("vec%0d.tag_last", i), {30'd0, rd_tag, rd_last}, {30'd0, tbl[i].tag, tbl[i].last});
      end
      step();
    end

    // Reset lands while the second beat of a pair is on the memory port.
    drive(1,0,0,0,0,0,0,1,14'h189);
    @(negedge clk); chk("rstmid.accept", {31'd0, spk_ready}, 32'd1);
    step();
    drive(1,0,0,0,0,0,0,0,0);
    step();
    drive(0,0,0,0,0,0,0,0,0);
    @(negedge clk); chk("rstmid.rd1_addr", {24'd0, mem_re, mem_addr}, {24'd0, 1'b1, 7'd3});
    step();
    @(negedge clk);
    chk("rstmid.mem_re", {31'd0, mem_re}, 32'd0);
    chk("rstmid.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.ready_in_rst", {29'd0, cfg_ready, swu_ready, spk_ready}, 32'd0);
    step();
    drive(1,0,0,0,0,0,0,1,14'h011);
    @(negedge clk); chk("rstmid.spk_ready", {31'd0, spk_ready}, 32'd1);
    step();
    drive(1,0,0,0,0,0,0,0,0);
    repeat (3) step();

    // Starvation: swu always valid; cfg must win on IDLE cycle 17, then again 18 cycles later.
    begin
      int g1, g2;
      g1 = 0; g2 = 0;
      drive(1,1,7'd7,32'hCAFE0001,1,7'd8,8'h3C,0,0);
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (cfg_ready && swu_ready) chk($sformatf("starve.onehot%0d", k), 32'd1, 32'd0);
        if (cfg_ready) begin
          if (g1 == 0) g1 = k;
          else if (g2 == 0) g2 = k;
        end
        step();
      end
      chk("starve.first_grant", g1, 32'd17);
      chk("starve.second_grant", g2, 32'd35);
    end
    drive(1,0,0,0,0,0,0,0,0);
    repeat (3) step();

    // Randomised run against a transaction-level reference.
    begin
      int free_at, wcnt, win;
      int order [3];
      logic [6:0] lo, hi;
      for (int i = 0; i < 128; i++) begin
        tbmem[i] <= fill(i) ^ 32'h5A5A_0000;
        model_mem[i] = fill(i) ^ 32'h5A5A_0000;
      end
      for (int i = 0; i < 8; i++) slot[i] = '0;
      free_at = 0;
      wcnt = 0;
      for (int c = 0; c < 3000; c++) begin
        drive(($urandom_range(0, 63) != 0), $urandom_range(0, 1), 7'($urandom), $urandom,
              ($urandom_range(0, 2) == 0), 7'($urandom), 8'($urandom),
              $urandom_range(0, 1),
              {(($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom)), 7'($urandom)});
        @(negedge clk);
        chk("rnd.we", {31'd0, mem_we}, {31'd0, slot[c%8].we});
        chk("rnd.re", {31'd0, mem_re}, {31'd0, slot[c%8].re});
        chk("rnd.addr", {25'd0, mem_addr}, {25'd0, slot[c%8].addr});
        chk("rnd.wdata", mem_wdata, slot[c%8].wdata);
        chk("rnd.rd_valid", {31'd0, rd_valid}, {31'd0, slot[c%8].rdv});
        chk("rnd.busy", {31'd0, busy}, {31'd0, slot[c%8].busy});
        if (slot[c%8].rdv) begin
          chk("rnd.rd_data", rd_data, slot[c%8].rdata);
          chk("rnd.tag_last", {30'd0, rd_tag, rd_last}, {30'd0, slot[c%8].tag, slot[c%8].last});
        end
        slot[c%8] = '0;

        win = -1;
        if (rst && c >= free_at) begin
          if (wcnt == 8) order = '{0, 1, 2};
          else order = '{1, 2, 0};
          for (int j = 0; j < 3; j++) begin
            if (win < 0 && ((order[j] == 0 && cfg_valid) || (order[j] == 1 && swu_valid) || (order[j] == 2 && spk_valid)))
              win = order[j];
          end
        end
        chk("rnd.ready", {29'd0, cfg_ready, swu_ready, spk_ready},
            {29'd0, win == 0, win == 1, win == 2});

        if (!rst) begin
          for (int i = 0; i < 8; i++) slot[i] = '0;
          free_at = c + 1;
          wcnt = 0;
        end else begin
          if (!cfg_valid || win == 0) wcnt = 0;
          else if (c >= free_at && wcnt < 8) wcnt++;
          if (win == 0 || win == 1) begin
            slot[(c+1)%8].we = 1'b1;
            slot[(c+1)%8].busy = 1'b1;
            slot[(c+1)%8].addr = (win == 0) ? cfg_addr : swu_addr;
            slot[(c+1)%8].wdata = (win == 0) ? cfg_data : {24'd0, swu_data};
            model_mem[slot[(c+1)%8].addr] = slot[(c+1)%8].wdata;
            free_at = c + 2;
          end else if (win == 2) begin
            lo = spk_addr[6:0];
            hi = spk_addr[13:7];
            slot[(c+1)%8].re = 1'b1;
            slot[(c+1)%8].busy = 1'b1;
            slot[(c+1)%8].addr = lo;
            slot[(c+2)%8].rdv = 1'b1;
            slot[(c+2)%8].rdata = model_mem[lo];
            slot[(c+2)%8].last = (hi == 7'd0);
            free_at = c + 2;
            if (hi != 7'd0) begin
              slot[(c+2)%8].re = 1'b1;
              slot[(c+2)%8].busy = 1'b1;
              slot[(c+2)%8].addr = hi;
              slot[(c+3)%8].rdv = 1'b1;
              slot[(c+3)%8].rdata = model_mem[hi];
              slot[(c+3)%8].tag = 1'b1;
              slot[(c+3)%8].last = 1'b1;
              free_at = c + 3;
            end
          end
        end
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
